// File: rtl/fwd_sel_ctrl.sv
// Operand-forwarding controller for the EX-stage operand muxes of a 5-stage pipeline.
// Shadows destination-register info of in-flight instructions and flags load-use hazards.
module fwd_sel_ctrl #(
   parameter int unsigned REG_AW    = 5,
   parameter bit          WB_BYPASS = 1'b1,
   parameter int unsigned CNT_W     = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [REG_AW-1:0] id_rs_i,
   input  logic [REG_AW-1:0] id_rt_i,
   input  logic [REG_AW-1:0] id_rd_i,
   input  logic              id_regwrite_i,
   input  logic              id_memread_i,
   input  logic              flush_i,
   output logic [1:0]        fwd_a_sel_o,
   output logic [1:0]        fwd_b_sel_o,
   output logic              stall_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   // EX stage needs its sources for select decode; later stages only need the producer side.
   typedef struct packed {
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic [REG_AW-1:0] rd;
      logic              we;
      logic              mr;
   } ex_stage_t;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic              we;
   } dst_stage_t;

   localparam logic [1:0] SelRegfile = 2'b00;
   localparam logic [1:0] SelMemWb   = 2'b01;
   localparam logic [1:0] SelExMem   = 2'b10;
   localparam logic [1:0] SelWbDone  = 2'b11;

   ex_stage_t         ex_q, ex_d;
   dst_stage_t        mem_q, mem_d;
   dst_stage_t        wb_q, wb_d;
   dst_stage_t        done_q, done_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic              stall;

   // A producer matches when it writes a nonzero register equal to the source.
   function automatic logic hit(input dst_stage_t s, input logic [REG_AW-1:0] src);
      return s.we && (s.rd != '0) && (s.rd == src);
   endfunction

   // Youngest producer wins; the WB-done bypass is optional.
   function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
      logic [1:0] sel;
      sel = SelRegfile;
      if (hit(mem_q, src)) begin
         sel = SelExMem;
      end else if (hit(wb_q, src)) begin
         sel = SelMemWb;
      end else if (WB_BYPASS && hit(done_q, src)) begin
         sel = SelWbDone;
      end
      return sel;
   endfunction

   // Load-use hazard: load in EX feeds the instruction currently in ID.
   always_comb begin
      stall = ex_q.mr && (ex_q.rd != '0) && ((ex_q.rd == id_rs_i) || (ex_q.rd == id_rt_i));
   end

   // Next-state: shift the shadow pipeline, bubble EX on stall or flush, count stalls.
   always_comb begin
      ex_d        = '0;
      mem_d       = '{rd: ex_q.rd, we: ex_q.we};
      wb_d        = mem_q;
      done_d      = wb_q;
      stall_cnt_d = stall_cnt_q;
      if (!(stall || flush_i)) begin
         ex_d = '{rs: id_rs_i, rt: id_rt_i, rd: id_rd_i, we: id_regwrite_i, mr: id_memread_i};
      end
      // A flush in the same cycle already supplies the bubble, so that cycle is not counted.
      if (stall && !flush_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   // Stage registers and counter with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         done_q      <= '0;
         stall_cnt_q <= '0;
      end else begin
         ex_q        <= ex_d;
         mem_q       <= mem_d;
         wb_q        <= wb_d;
         done_q      <= done_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Output decode, combinational from the stage registers.
   always_comb begin
      fwd_a_sel_o = fwd_sel(ex_q.rs);
      fwd_b_sel_o = fwd_sel(ex_q.rt);
      stall_o     = stall;
      stall_cnt_o = stall_cnt_q;
   end

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// Directed bench for fwd_sel_ctrl; a second instance (no WB bypass, 4-bit counter)
// shares the stimulus to cover the bypass-disabled and saturation cases.
module tb_fwd_sel_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs, id_rt, id_rd;
   logic       id_we, id_mr, flush;
   logic [1:0] a_sel, b_sel, a_sel_s, b_sel_s;
   logic       stall, stall_s;
   logic [15:0] cnt;
   logic [3:0]  cnt_s;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   fwd_sel_ctrl #(.REG_AW(5), .WB_BYPASS(1'b1), .CNT_W(16)) dut (
      .clk_i(clk), .rst_i(rst), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd),
      .id_regwrite_i(id_we), .id_memread_i(id_mr), .flush_i(flush),
      .fwd_a_sel_o(a_sel), .fwd_b_sel_o(b_sel), .stall_o(stall), .stall_cnt_o(cnt)
   );

   fwd_sel_ctrl #(.REG_AW(5), .WB_BYPASS(1'b0), .CNT_W(4)) dut_s (
      .clk_i(clk), .rst_i(rst), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd),
      .id_regwrite_i(id_we), .id_memread_i(id_mr), .flush_i(flush),
      .fwd_a_sel_o(a_sel_s), .fwd_b_sel_o(b_sel_s), .stall_o(stall_s), .stall_cnt_o(cnt_s)
   );

   // Present an instruction in ID; outputs are sampled 2 time units later.
   task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic we, input logic mr);
      id_rs = rs; id_rt = rt; id_rd = rd; id_we = we; id_mr = mr;
      #2;
   endtask

   task automatic nop();
      set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      nop();
      flush = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      nop();
      total++; if (a_sel !== 2'b00) $display("FAIL reset_a got %b want 00", a_sel); else passed++;
      total++; if (b_sel !== 2'b00) $display("FAIL reset_b got %b want 00", b_sel); else passed++;
      total++; if (stall !== 1'b0) $display("FAIL reset_stall got %b want 0", stall); else passed++;
      total++; if (cnt !== 16'd0) $display("FAIL reset_cnt got %0d want 0", cnt); else passed++;
   endtask

   // add $3,$1,$2 ; sub $6,$3,$4
   task automatic test_ex_mem_fwd();
      do_reset();
      set_id(5'd1, 5'd2, 5'd3, 1'b1, 1'b0); tick();
      set_id(5'd3, 5'd4, 5'd6, 1'b1, 1'b0); tick();
      nop();
      total++; if (a_sel !== 2'b10) $display("FAIL exmem_a got %b want 10", a_sel); else passed++;
      total++; if (b_sel !== 2'b00) $display("FAIL exmem_b got %b want 00", b_sel); else passed++;
      total++; if (stall !== 1'b0) $display("FAIL exmem_stall got %b want 0", stall); else passed++;
   endtask

   // add $3 ; nop ; or $4,$3,$3
   task automatic test_mem_wb_fwd();
      do_reset();
      set_id(5'd1, 5'd2, 5'd3, 1'b1, 1'b0); tick();
      nop(); tick();
      set_id(5'd3, 5'd3, 5'd4, 1'b1, 1'b0); tick();
      nop();
      total++; if (a_sel !== 2'b01) $display("FAIL memwb_a got %b want 01", a_sel); else passed++;
      total++; if (b_sel !== 2'b01) $display("FAIL memwb_b got %b want 01", b_sel); else passed++;
   endtask

   // add $3 ; add $3 ; consumer $3,$7 -> youngest wins
   task automatic test_youngest();
      do_reset();
      set_id(5'd1, 5'd2, 5'd3, 1'b1, 1'b0); tick();
      set_id(5'd5, 5'd6, 5'd3, 1'b1, 1'b0); tick();
      set_id(5'd3, 5'd7, 5'd8, 1'b1, 1'b0); tick();
      nop();
      total++; if (a_sel !== 2'b10) $display("FAIL young_a got %b want 10", a_sel); else passed++;
      total++; if (b_sel !== 2'b00) $display("FAIL young_b got %b want 00", b_sel); else passed++;
   endtask

   // add $3 ; nop ; nop ; consumer $3,$3 -> 11 with bypass, 00 without
   task automatic test_wb_done();
      do_reset();
      set_id(5'd1, 5'd2, 5'd3, 1'b1, 1'b0); tick();
      nop(); tick();
      nop(); tick();
      set_id(5'd3, 5'd3, 5'd9, 1'b1, 1'b0); tick();
      nop();
      total++; if (a_sel !== 2'b11) $display("FAIL done_a got %b want 11", a_sel); else passed++;
      total++; if (b_sel !== 2'b11) $display("FAIL done_b got %b want 11", b_sel); else passed++;
      total++; if (a_sel_s !== 2'b00) $display("FAIL nobyp_a got %b want 00", a_sel_s); else passed++;
      total++; if (b_sel_s !== 2'b00) $display("FAIL nobyp_b got %b want 00", b_sel_s); else passed++;
   endtask

   // lw $5 ; add $6,$2,$5 -> one stall, then MEM/WB forward
   task automatic test_load_use();
      do_reset();
      set_id(5'd1, 5'd5, 5'd5, 1'b1, 1'b1); tick();
      set_id(5'd2, 5'd5, 5'd6, 1'b1, 1'b0);
      total++; if (stall !== 1'b1) $display("FAIL lu_stall got %b want 1", stall); else passed++;
      total++; if (cnt !== 16'd0) $display("FAIL lu_cnt0 got %0d want 0", cnt); else passed++;
      tick(); #2;
      total++; if (stall !== 1'b0) $display("FAIL lu_stall2 got %b want 0", stall); else passed++;
      total++; if (cnt !== 16'd1) $display("FAIL lu_cnt1 got %0d want 1", cnt); else passed++;
      total++; if (a_sel !== 2'b00) $display("FAIL lu_bubble_a got %b want 00", a_sel); else passed++;
      tick();
      nop();
      total++; if (b_sel !== 2'b01) $display("FAIL lu_b got %b want 01", b_sel); else passed++;
      total++; if (a_sel !== 2'b00) $display("FAIL lu_a got %b want 00", a_sel); else passed++;
      total++; if (cnt !== 16'd1) $display("FAIL lu_cnt_hold got %0d want 1", cnt); else passed++;
   endtask

   // Same hazard with flush asserted: bubble once, no count.
   task automatic test_flush_stall();
      do_reset();
      set_id(5'd1, 5'd5, 5'd5, 1'b1, 1'b1); tick();
      flush = 1'b1;
      set_id(5'd2, 5'd5, 5'd6, 1'b1, 1'b0);
      total++; if (stall !== 1'b1) $display("FAIL fl_stall got %b want 1", stall); else passed++;
      tick();
      flush = 1'b0;
      nop();
      total++; if (cnt !== 16'd0) $display("FAIL fl_cnt got %0d want 0", cnt); else passed++;
      total++; if (stall !== 1'b0) $display("FAIL fl_stall2 got %b want 0", stall); else passed++;
   endtask

   // Writes to $0 never forward or stall.
   task automatic test_reg_zero();
      do_reset();
      set_id(5'd1, 5'd2, 5'd0, 1'b1, 1'b0); tick();
      for (int d = 1; d <= 3; d++) begin
         set_id(5'd0, 5'd0, 5'd7, 1'b1, 1'b0); tick();
         nop();
         total++;
         if (a_sel !== 2'b00 || b_sel !== 2'b00)
            $display("FAIL zero_d%0d got %b/%b want 00/00", d, a_sel, b_sel);
         else passed++;
      end
      do_reset();
      set_id(5'd1, 5'd0, 5'd0, 1'b1, 1'b1); tick();
      set_id(5'd0, 5'd0, 5'd4, 1'b1, 1'b0);
      total++; if (stall !== 1'b0) $display("FAIL zero_load got %b want 0", stall); else passed++;
   endtask

   // Reset with producers in flight discards them.
   task automatic test_reset_mid();
      do_reset();
      set_id(5'd1, 5'd5, 5'd5, 1'b1, 1'b1); tick();
      set_id(5'd5, 5'd0, 5'd0, 1'b0, 1'b0); tick();   // stalled once
      set_id(5'd1, 5'd2, 5'd3, 1'b1, 1'b0); tick();
      set_id(5'd1, 5'd2, 5'd4, 1'b1, 1'b0); tick();
      set_id(5'd3, 5'd4, 5'd8, 1'b1, 1'b0); tick();
      nop();
      total++; if (a_sel !== 2'b01 || b_sel !== 2'b10)
         $display("FAIL pre_rst got %b/%b want 01/10", a_sel, b_sel); else passed++;
      total++; if (cnt !== 16'd1) $display("FAIL pre_rst_cnt got %0d want 1", cnt); else passed++;
      set_id(5'd3, 5'd4, 5'd8, 1'b1, 1'b0);
      rst = 1'b1; tick(); rst = 1'b0;
      set_id(5'd3, 5'd4, 5'd9, 1'b1, 1'b0);
      total++; if (a_sel !== 2'b00 || b_sel !== 2'b00)
         $display("FAIL post_rst got %b/%b want 00/00", a_sel, b_sel); else passed++;
      total++; if (stall !== 1'b0) $display("FAIL post_rst_stall got %b want 0", stall); else passed++;
      total++; if (cnt !== 16'd0) $display("FAIL post_rst_cnt got %0d want 0", cnt); else passed++;
   endtask

   // 20 load-use stalls: 4-bit counter saturates at 15, 16-bit counter reaches 20.
   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 20; i++) begin
         set_id(5'd1, 5'd5, 5'd5, 1'b1, 1'b1); tick();
         set_id(5'd5, 5'd0, 5'd6, 1'b1, 1'b0); tick();
      end
      nop();
      total++; if (cnt_s !== 4'hF) $display("FAIL sat_cnt got %0d want 15", cnt_s); else passed++;
      total++; if (cnt !== 16'd20) $display("FAIL big_cnt got %0d want 20", cnt); else passed++;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0;
      id_rs = '0; id_rt = '0; id_rd = '0; id_we = 1'b0; id_mr = 1'b0;
      test_reset();
      test_ex_mem_fwd();
      test_mem_wb_fwd();
      test_youngest();
      test_wb_done();
      test_load_use();
      test_flush_stall();
      test_reg_zero();
      test_reset_mid();
      test_saturation();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
